tri_eccchk: RTL and testbench

- Consumes the syndrome produced by the upstream ECC syndrome generator (tri_eccgen) together with the same protected word.
- Decodes the syndrome, corrects single-bit errors and flags uncorrectable ones.
- Registers the result in a one-deep valid/ready pipeline stage and keeps saturating CE/UE event counters for RAS reporting.
- Sits between array read data (plus its syndrome generator) and the consuming unit.

---
 rtl/tri_eccchk.sv | 204 ++++++++++++++++++++
 tb/tb_tri_eccchk.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_eccchk.sv
`default_nettype none
// ============================================================================
// tri_eccchk - SEC-DED syndrome decode/correct, one-deep valid/ready output
// stage, saturating CE/UE counters. Optional capture: TRI_ECCCHK_ERRCAP_EN.
// Revision 1.0
// ============================================================================
module tri_eccchk #(
    parameter int REGSIZE   = 64,
    parameter int CNT_WIDTH = 8,
    localparam int CW       = 9 - (64 / REGSIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    output logic                  in_rdy,
    input  logic [0:REGSIZE+CW-1] din,
    input  logic [0:CW-1]         syn,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [0:REGSIZE-1]    dout,
    output logic                  ce,
    output logic                  ue,
`ifdef TRI_ECCCHK_ERRCAP_EN
    output logic                  errcap_vld,
    output logic                  errcap_ue,
    output logic [0:CW-1]         errcap_syn,
`endif
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  ce_cnt,
    output logic [CNT_WIDTH-1:0]  ue_cnt
);

    function automatic logic [CW-1:0] onehot(input int p);
        logic [CW-1:0] r;
        r = '0;
        r[CW-1-p] = 1'b1;
        return r;
    endfunction

    // H-matrix columns: data bits take the weight-3 then weight-5 patterns in
    // lexicographic order of set positions (syndrome position 0 is the MSB);
    // check bit j owns the one-hot column at position j.
    function automatic logic [(REGSIZE+CW)*CW-1:0] build_cols();
        logic [(REGSIZE+CW)*CW-1:0] t;
        int n;
        t = '0;
        n = 0;
        for (int a = 0; a < CW; a++)
            for (int b = a + 1; b < CW; b++)
                for (int c = b + 1; c < CW; c++) begin
                    if (n < REGSIZE)
                        t[n*CW +: CW] = onehot(a) | onehot(b) | onehot(c);
                    n++;
                end
        for (int a = 0; a < CW; a++)
            for (int b = a + 1; b < CW; b++)
                for (int c = b + 1; c < CW; c++)
                    for (int d = c + 1; d < CW; d++)
                        for (int e = d + 1; e < CW; e++) begin
                            if (n < REGSIZE)
                                t[n*CW +: CW] = onehot(a) | onehot(b) | onehot(c)
                                              | onehot(d) | onehot(e);
                            n++;
                        end
        for (int j = 0; j < CW; j++)
            t[(REGSIZE+j)*CW +: CW] = onehot(j);
        return t;
    endfunction

    localparam logic [(REGSIZE+CW)*CW-1:0] C_COLS = build_cols();

    logic [CW-1:0]      w_syn;
    logic [0:REGSIZE-1] w_flip;
    logic [0:REGSIZE-1] w_data;
    logic               w_hit;
    logic               w_ce;
    logic               w_ue;
    logic               w_xfer;
    logic               w_unused_chk;

    logic                 out_val_q, out_val_d;
    logic [0:REGSIZE-1]   dout_q,    dout_d;
    logic                 ce_q,      ce_d;
    logic                 ue_q,      ue_d;
    logic [CNT_WIDTH-1:0] ce_cnt_q,  ce_cnt_d;
    logic [CNT_WIDTH-1:0] ue_cnt_q,  ue_cnt_d;
`ifdef TRI_ECCCHK_ERRCAP_EN
    logic                 errcap_vld_q, errcap_vld_d;
    logic                 errcap_ue_q,  errcap_ue_d;
    logic [CW-1:0]        errcap_syn_q, errcap_syn_d;
`endif

    assign w_syn  = syn;
    // Check bits pass through uncorrected; only the syndrome locates errors.
    assign w_unused_chk = ^din[REGSIZE:REGSIZE+CW-1];

    always_comb begin
        w_flip = '0;
        w_hit  = 1'b0;
        for (int i = 0; i < REGSIZE; i++) begin
            if (w_syn == C_COLS[i*CW +: CW]) begin
                w_flip[i] = 1'b1;
                w_hit     = 1'b1;
            end
        end
        for (int j = 0; j < CW; j++) begin
            if (w_syn == C_COLS[(REGSIZE+j)*CW +: CW])
                w_hit = 1'b1;
        end
        w_ce = w_hit;
        w_ue = (w_syn != '0) && !w_hit;
    end

    assign w_data = din[0:REGSIZE-1] ^ w_flip;
    assign in_rdy = ~out_val_q | out_rdy;
    assign w_xfer = in_val & in_rdy;

    always_comb begin
        out_val_d = out_val_q;
        dout_d    = dout_q;
        ce_d      = ce_q;
        ue_d      = ue_q;
        ce_cnt_d  = ce_cnt_q;
        ue_cnt_d  = ue_cnt_q;
        if (w_xfer) begin
            out_val_d = 1'b1;
            dout_d    = w_data;
            ce_d      = w_ce;
            ue_d      = w_ue;
        end else if (out_rdy) begin
            out_val_d = 1'b0;
        end
        if (cnt_clr) begin
            ce_cnt_d = '0;
            ue_cnt_d = '0;
        end else begin
            if (w_xfer && w_ce && (ce_cnt_q != '1))
                ce_cnt_d = ce_cnt_q + CNT_WIDTH'(1);
            if (w_xfer && w_ue && (ue_cnt_q != '1))
                ue_cnt_d = ue_cnt_q + CNT_WIDTH'(1);
        end
    end

`ifdef TRI_ECCCHK_ERRCAP_EN
    always_comb begin
        errcap_vld_d = errcap_vld_q;
        errcap_ue_d  = errcap_ue_q;
        errcap_syn_d = errcap_syn_q;
        if (cnt_clr) begin
            errcap_vld_d = 1'b0;
            errcap_ue_d  = 1'b0;
            errcap_syn_d = '0;
        end else if (w_xfer && (w_ce || w_ue) &&
                     (!errcap_vld_q || (w_ue && !errcap_ue_q))) begin
            errcap_vld_d = 1'b1;
            errcap_ue_d  = w_ue;
            errcap_syn_d = w_syn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errcap_vld_q <= 1'b0;
            errcap_ue_q  <= 1'b0;
            errcap_syn_q <= '0;
        end else begin
            errcap_vld_q <= errcap_vld_d;
            errcap_ue_q  <= errcap_ue_d;
            errcap_syn_q <= errcap_syn_d;
        end
    end

    assign errcap_vld = errcap_vld_q;
    assign errcap_ue  = errcap_ue_q;
    assign errcap_syn = errcap_syn_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_val_q <= 1'b0;
            dout_q    <= '0;
            ce_q      <= 1'b0;
            ue_q      <= 1'b0;
            ce_cnt_q  <= '0;
            ue_cnt_q  <= '0;
        end else begin
            out_val_q <= out_val_d;
            dout_q    <= dout_d;
            ce_q      <= ce_d;
            ue_q      <= ue_d;
            ce_cnt_q  <= ce_cnt_d;
            ue_cnt_q  <= ue_cnt_d;
        end
    end

    assign out_val = out_val_q;
    assign dout    = dout_q;
    assign ce      = ce_q;
    assign ue      = ue_q;
    assign ce_cnt  = ce_cnt_q;
    assign ue_cnt  = ue_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_eccchk.sv
`default_nettype none
// ============================================================================
// tb_tri_eccchk - directed self-checking bench for tri_eccchk (REGSIZE 64/32).
// Revision 1.0
// ============================================================================
module tb_tri_eccchk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic        in_val, in_rdy, out_val, out_rdy, ce, ue, cnt_clr;
    logic [0:71] din;
    logic [0:7]  syn;
    logic [0:63] dout;
    logic [7:0]  ce_cnt, ue_cnt;

    logic        in_val32, in_rdy32, out_val32, out_rdy32, ce32, ue32, cnt_clr32;
    logic [0:38] din32;
    logic [0:6]  syn32;
    logic [0:31] dout32;
    logic [7:0]  ce_cnt32, ue_cnt32;

`ifdef TRI_ECCCHK_ERRCAP_EN
    logic        ec_vld, ec_ue, ec_vld32, ec_ue32;
    logic [0:7]  ec_syn;
    logic [0:6]  ec_syn32;
`endif

    tri_eccchk #(.REGSIZE(64), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .din(din), .syn(syn),
        .out_val(out_val), .out_rdy(out_rdy), .dout(dout), .ce(ce), .ue(ue),
`ifdef TRI_ECCCHK_ERRCAP_EN
        .errcap_vld(ec_vld), .errcap_ue(ec_ue), .errcap_syn(ec_syn),
`endif
        .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
    );

    tri_eccchk #(.REGSIZE(32), .CNT_WIDTH(8)) dut32 (
        .clk(clk), .rst(rst), .in_val(in_val32), .in_rdy(in_rdy32), .din(din32), .syn(syn32),
        .out_val(out_val32), .out_rdy(out_rdy32), .dout(dout32), .ce(ce32), .ue(ue32),
`ifdef TRI_ECCCHK_ERRCAP_EN
        .errcap_vld(ec_vld32), .errcap_ue(ec_ue32), .errcap_syn(ec_syn32),
`endif
        .cnt_clr(cnt_clr32), .ce_cnt(ce_cnt32), .ue_cnt(ue_cnt32)
    );

    localparam logic [63:0] D   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2  = 64'hFEDC_BA98_7654_3210;
    localparam logic [31:0] D32 = 32'h89AB_CDEF;

    // Generator model: scan patterns in descending numeric order by weight.
    function automatic logic [7:0] col(input int cw, input int rs, input int i);
        logic [7:0] r;
        int n;
        r = 8'h00;
        n = 0;
        if (i >= rs) begin
            r = 8'(1 << (cw - 1 - (i - rs)));
        end else begin
            for (int w = 3; w <= 5; w += 2)
                for (int v = (1 << cw) - 1; v > 0; v--)
                    if ($countones(v) == w) begin
                        if (n == i) r = 8'(v);
                        n++;
                    end
        end
        return r;
    endfunction

    function automatic logic [7:0] gen_syn(input int cw, input int rs, input logic [0:71] w);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < rs + cw; i++)
            if (w[i]) s = s ^ col(cw, rs, i);
        return s;
    endfunction

    function automatic logic [0:71] enc64(input logic [63:0] d);
        logic [0:71] w;
        w = {d, 8'h00};
        return {d, gen_syn(8, 64, w)};
    endfunction

    function automatic logic [0:71] enc32(input logic [31:0] d);
        logic [0:71] w;
        logic [7:0]  s;
        w = {d, 40'h0};
        s = gen_syn(7, 32, w);
        return {d, s[6:0], 33'h0};
    endfunction

    task automatic put64(input logic v, input logic [0:71] w, input logic [7:0] s);
        in_val = v;
        din    = w;
        syn    = s;
    endtask

    task automatic put32(input logic v, input logic [0:71] w, input logic [6:0] s);
        in_val32 = v;
        din32    = w[0:38];
        syn32    = s;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_val = 1'b0; out_rdy = 1'b1; cnt_clr = 1'b0; din = '0; syn = '0;
        in_val32 = 1'b0; out_rdy32 = 1'b1; cnt_clr32 = 1'b0; din32 = '0; syn32 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_hs: out_val=%b in_rdy=%b want 0/1", out_val, in_rdy);
        end
        checks++;
        if (dout !== 64'h0 || ce !== 1'b0 || ue !== 1'b0 || ce_cnt !== 8'h0 || ue_cnt !== 8'h0) begin
            errors++; $display("FAIL reset_state: dout=%h ce=%b ue=%b cnt=%h/%h want zeros", dout, ce, ue, ce_cnt, ue_cnt);
        end
        checks++;
        if (out_val32 !== 1'b0 || in_rdy32 !== 1'b1 || dout32 !== 32'h0 || ce_cnt32 !== 8'h0) begin
            errors++; $display("FAIL reset_32: out_val=%b in_rdy=%b dout=%h cnt=%h", out_val32, in_rdy32, dout32, ce_cnt32);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_vld !== 1'b0 || ec_ue !== 1'b0 || ec_syn !== 8'h0) begin
            errors++; $display("FAIL reset_errcap: vld=%b ue=%b syn=%b want 0", ec_vld, ec_ue, ec_syn);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean;
        logic [63:0] dat [4];
        dat = '{D, ~D, {D[31:0], D[63:32]}, D + 64'd1};
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            put64(1'b1, enc64(dat[k]), gen_syn(8, 64, enc64(dat[k])));
            #1;
            checks++;
            if (in_rdy !== 1'b1) begin
                errors++; $display("FAIL clean_rdy[%0d]: in_rdy=%b want 1", k, in_rdy);
            end
            @(negedge clk);
            checks++;
            if (out_val !== 1'b1 || dout !== dat[k] || ce !== 1'b0 || ue !== 1'b0) begin
                errors++; $display("FAIL clean_out[%0d]: val=%b dout=%h ce=%b ue=%b want 1 %h 0 0", k, out_val, dout, ce, ue, dat[k]);
            end
        end
        in_val = 1'b0;
        @(negedge clk);
        checks++;
        if (out_val !== 1'b0 || ce_cnt !== 8'h0 || ue_cnt !== 8'h0) begin
            errors++; $display("FAIL clean_end: val=%b cnt=%h/%h want 0 00/00", out_val, ce_cnt, ue_cnt);
        end
    endtask

    task automatic test_single;
        logic [0:71] f;
        f = '0; f[0] = 1'b1;
        put64(1'b1, enc64(D) ^ f, 8'b1110_0000);
        @(negedge clk);
        checks++;
        if (dout !== D || ce !== 1'b1 || ue !== 1'b0 || ce_cnt !== 8'd1 || ue_cnt !== 8'd0) begin
            errors++; $display("FAIL single_d0: dout=%h ce=%b ue=%b cnt=%0d/%0d want %h 1 0 1/0", dout, ce, ue, ce_cnt, ue_cnt, D);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_vld !== 1'b1 || ec_ue !== 1'b0 || ec_syn !== 8'b1110_0000) begin
            errors++; $display("FAIL errcap_ce: vld=%b ue=%b syn=%b want 1 0 11100000", ec_vld, ec_ue, ec_syn);
        end
`endif
        f = '0; f[71] = 1'b1;
        put64(1'b1, enc64(D) ^ f, 8'b0000_0001);
        @(negedge clk);
        checks++;
        if (dout !== D || ce !== 1'b1 || ue !== 1'b0 || ce_cnt !== 8'd2) begin
            errors++; $display("FAIL single_c71: dout=%h ce=%b ue=%b cnt=%0d want %h 1 0 2", dout, ce, ue, ce_cnt, D);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_vld !== 1'b1 || ec_ue !== 1'b0 || ec_syn !== 8'b1110_0000) begin
            errors++; $display("FAIL errcap_hold: vld=%b ue=%b syn=%b want 1 0 11100000", ec_vld, ec_ue, ec_syn);
        end
`endif
    endtask

    task automatic test_double;
        logic [0:71] f;
        f = '0; f[0] = 1'b1; f[1] = 1'b1;
        put64(1'b1, enc64(D) ^ f, 8'b0011_0000);
        @(negedge clk);
        checks++;
        if (dout !== (D ^ 64'hC000_0000_0000_0000) || ue !== 1'b1 || ce !== 1'b0 ||
            ue_cnt !== 8'd1 || ce_cnt !== 8'd2) begin
            errors++; $display("FAIL double_01: dout=%h ce=%b ue=%b cnt=%0d/%0d want %h 0 1 2/1", dout, ce, ue, ce_cnt, ue_cnt, D ^ 64'hC000_0000_0000_0000);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_vld !== 1'b1 || ec_ue !== 1'b1 || ec_syn !== 8'b0011_0000) begin
            errors++; $display("FAIL errcap_ue: vld=%b ue=%b syn=%b want 1 1 00110000", ec_vld, ec_ue, ec_syn);
        end
`endif
        f = '0; f[0] = 1'b1; f[2] = 1'b1;
        put64(1'b1, enc64(D) ^ f, 8'b0010_1000);
        @(negedge clk);
        checks++;
        if (dout !== (D ^ 64'hA000_0000_0000_0000) || ue !== 1'b1 || ce !== 1'b0 || ue_cnt !== 8'd2) begin
            errors++; $display("FAIL double_02: dout=%h ce=%b ue=%b ue_cnt=%0d want %h 0 1 2", dout, ce, ue, ue_cnt, D ^ 64'hA000_0000_0000_0000);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_ue !== 1'b1 || ec_syn !== 8'b0011_0000) begin
            errors++; $display("FAIL errcap_ue_hold: ue=%b syn=%b want 1 00110000", ec_ue, ec_syn);
        end
`endif
        in_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [0:71] a, b;
        a = enc64(D ^ 64'h1111);
        b = enc64(D2); b[5] = ~b[5];
        out_rdy = 1'b0;
        put64(1'b1, a, gen_syn(8, 64, a));
        @(negedge clk);
        checks++;
        if (out_val !== 1'b1 || dout !== (D ^ 64'h1111) || in_rdy !== 1'b0) begin
            errors++; $display("FAIL bp_load: val=%b dout=%h in_rdy=%b want 1 %h 0", out_val, dout, in_rdy, D ^ 64'h1111);
        end
        put64(1'b1, b, gen_syn(8, 64, b));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_rdy !== 1'b0 || dout !== (D ^ 64'h1111) || ce !== 1'b0 || ue !== 1'b0 || ce_cnt !== 8'd2) begin
                errors++; $display("FAIL bp_stall[%0d]: in_rdy=%b dout=%h ce=%b ue=%b ce_cnt=%0d want 0 %h 0 0 2", k, in_rdy, dout, ce, ue, ce_cnt, D ^ 64'h1111);
            end
        end
        out_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_release: in_rdy=%b want 1", in_rdy);
        end
        @(negedge clk);
        checks++;
        if (out_val !== 1'b1 || dout !== D2 || ce !== 1'b1 || ce_cnt !== 8'd3) begin
            errors++; $display("FAIL bp_next: val=%b dout=%h ce=%b ce_cnt=%0d want 1 %h 1 3", out_val, dout, ce, ce_cnt, D2);
        end
        in_val = 1'b0;
        @(negedge clk);
        checks++;
        if (out_val !== 1'b0 || ce_cnt !== 8'd3) begin
            errors++; $display("FAIL bp_drain: val=%b ce_cnt=%0d want 0 3", out_val, ce_cnt);
        end
    endtask

    task automatic test_saturate;
        logic [0:71] w;
        out_rdy = 1'b1;
        for (int k = 0; k < 260; k++) begin
            w = enc64(D);
            w[k % 64] = ~w[k % 64];
            put64(1'b1, w, gen_syn(8, 64, w));
            @(negedge clk);
            if (k == 99) begin
                checks++;
                if (ce_cnt !== 8'd103 || dout !== D || ce !== 1'b1) begin
                    errors++; $display("FAIL sat_mid: ce_cnt=%0d dout=%h ce=%b want 103 %h 1", ce_cnt, dout, ce, D);
                end
            end
        end
        checks++;
        if (ce_cnt !== 8'hFF || ue_cnt !== 8'd2) begin
            errors++; $display("FAIL sat_end: ce_cnt=%h ue_cnt=%0d want ff 2", ce_cnt, ue_cnt);
        end
        w = enc64(D); w[3] = ~w[3];
        put64(1'b1, w, gen_syn(8, 64, w));
        cnt_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (ce_cnt !== 8'h0 || ue_cnt !== 8'h0 || ce !== 1'b1) begin
            errors++; $display("FAIL clr_prio: ce_cnt=%h ue_cnt=%h ce=%b want 00 00 1", ce_cnt, ue_cnt, ce);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_vld !== 1'b0 || ec_ue !== 1'b0 || ec_syn !== 8'h0) begin
            errors++; $display("FAIL errcap_clr: vld=%b ue=%b syn=%b want 0", ec_vld, ec_ue, ec_syn);
        end
`endif
        cnt_clr = 1'b0;
        w = enc64(D); w[1] = ~w[1];
        put64(1'b1, w, 8'b1101_0000);
        @(negedge clk);
        checks++;
        if (ce_cnt !== 8'd1 || dout !== D) begin
            errors++; $display("FAIL clr_recount: ce_cnt=%0d dout=%h want 1 %h", ce_cnt, dout, D);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_vld !== 1'b1 || ec_ue !== 1'b0 || ec_syn !== 8'b1101_0000) begin
            errors++; $display("FAIL errcap_recap: vld=%b ue=%b syn=%b want 1 0 11010000", ec_vld, ec_ue, ec_syn);
        end
`endif
        in_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        out_rdy = 1'b0;
        put64(1'b1, enc64(D2), gen_syn(8, 64, enc64(D2)));
        @(negedge clk);
        checks++;
        if (out_val !== 1'b1 || in_rdy !== 1'b0) begin
            errors++; $display("FAIL rstmid_pre: val=%b in_rdy=%b want 1 0", out_val, in_rdy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_val !== 1'b0 || in_rdy !== 1'b1 || dout !== 64'h0 || ce_cnt !== 8'h0 || ue_cnt !== 8'h0) begin
            errors++; $display("FAIL rstmid_async: val=%b in_rdy=%b dout=%h cnt=%h/%h want 0 1 0 00/00", out_val, in_rdy, dout, ce_cnt, ue_cnt);
        end
        in_val = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (out_val !== 1'b0 || dout !== 64'h0) begin
            errors++; $display("FAIL rstmid_post: val=%b dout=%h want 0 0", out_val, dout);
        end
    endtask

    task automatic test_r32;
        logic [0:71] f;
        f = '0; f[0] = 1'b1;
        put32(1'b1, enc32(D32) ^ f, 7'b111_0000);
        @(negedge clk);
        checks++;
        if (dout32 !== D32 || ce32 !== 1'b1 || ue32 !== 1'b0 || ce_cnt32 !== 8'd1) begin
            errors++; $display("FAIL r32_d0: dout=%h ce=%b ue=%b cnt=%0d want %h 1 0 1", dout32, ce32, ue32, ce_cnt32, D32);
        end
        f = '0; f[38] = 1'b1;
        put32(1'b1, enc32(D32) ^ f, 7'b000_0001);
        @(negedge clk);
        checks++;
        if (dout32 !== D32 || ce32 !== 1'b1 || ce_cnt32 !== 8'd2) begin
            errors++; $display("FAIL r32_c38: dout=%h ce=%b cnt=%0d want %h 1 2", dout32, ce32, ce_cnt32, D32);
        end
        f = '0; f[0] = 1'b1; f[1] = 1'b1;
        put32(1'b1, enc32(D32) ^ f, 7'b001_1000);
        @(negedge clk);
        checks++;
        if (dout32 !== (D32 ^ 32'hC000_0000) || ue32 !== 1'b1 || ce32 !== 1'b0 || ue_cnt32 !== 8'd1) begin
            errors++; $display("FAIL r32_double: dout=%h ce=%b ue=%b ue_cnt=%0d want %h 0 1 1", dout32, ce32, ue32, ue_cnt32, D32 ^ 32'hC000_0000);
        end
`ifdef TRI_ECCCHK_ERRCAP_EN
        checks++;
        if (ec_vld32 !== 1'b1 || ec_ue32 !== 1'b1 || ec_syn32 !== 7'b001_1000) begin
            errors++; $display("FAIL r32_errcap: vld=%b ue=%b syn=%b want 1 1 0011000", ec_vld32, ec_ue32, ec_syn32);
        end
`endif
        put32(1'b1, enc32(~D32), gen_syn(7, 32, enc32(~D32)) & 8'h7F);
        @(negedge clk);
        checks++;
        if (dout32 !== ~D32 || ce32 !== 1'b0 || ue32 !== 1'b0 || ce_cnt32 !== 8'd2) begin
            errors++; $display("FAIL r32_clean: dout=%h ce=%b ue=%b ce_cnt=%0d want %h 0 0 2", dout32, ce32, ue32, ce_cnt32, ~D32);
        end
        in_val32 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_r32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
